// File: rtl/sha_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : sha_block_loader
// Brief    : Streams one pre-padded 512-bit block into a memory-mapped SHA-256
//            core, starts it, waits for done and returns the 256-bit digest.
//            Optional WAIT timeout: define SHA_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sha_block_loader (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         first_in,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic [31:0]  core_a,
    output logic [31:0]  core_d,
    input  logic [31:0]  core_dout,
    input  logic [31:0]  core_status,
    output logic         dig_valid,
    output logic [255:0] dig_data,
    input  logic         dig_ready,
    output logic         busy,
    output logic         err
);
    localparam logic [31:0] c_addr_init0 = 32'h2000_0000;
    localparam logic [31:0] c_addr_init1 = 32'h4000_0000;
    localparam logic [31:0] c_addr_start = 32'h8000_0000;
    localparam logic [31:0] c_addr_h0    = 32'h0000_0010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_START = 3'd4,
        S_WAIT  = 3'd5,
        S_READ  = 3'd6,
        S_OUT   = 3'd7
    } state_t;

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [5:0]        r_step;
    logic [31:0]       r_words [16];
    logic              r_w_ready;
    logic [31:0]       r_core_a;
    logic [31:0]       r_core_d;
    logic              r_dig_valid;
    logic [0:7][31:0]  r_h;

    logic w_accept;
    logic w_wait_exit;
    logic w_unused_status;

    assign w_accept        = w_valid & r_w_ready;
    assign w_unused_status = ^core_status[31:1];

`ifdef SHA_LOADER_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'd4095;
    logic [15:0] r_tmo;
    logic        r_abort;
    logic        r_err;
    assign w_wait_exit = core_status[0] & ~r_abort;
    assign err         = r_err;
`else
    assign w_wait_exit = core_status[0];
    assign err         = 1'b0;
`endif

    // Word buffer is pure datapath; w_ready is low whenever reset is active.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_words[r_idx] <= w_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_step      <= 6'd0;
            r_w_ready   <= 1'b0;
            r_core_a    <= 32'd0;
            r_core_d    <= 32'd0;
            r_dig_valid <= 1'b0;
            r_h         <= '0;
`ifdef SHA_LOADER_TIMEOUT_EN
            r_tmo       <= 16'd0;
            r_abort     <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_w_ready <= 1'b1;
                    r_core_a  <= 32'd0;
                    r_core_d  <= 32'd0;
                    if (w_accept) begin
                        r_idx  <= 4'd1;
                        r_step <= 6'd0;
                        if (first_in) begin
                            r_state   <= S_INIT;
                            r_w_ready <= 1'b0;
                            r_core_a  <= c_addr_init0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_INIT: begin
                    r_step <= r_step + 6'd1;
                    if (r_step[1:0] == 2'd1) begin
                        r_core_a <= c_addr_init1;
                    end else if (r_step[1:0] == 2'd3) begin
                        r_state   <= S_LOAD;
                        r_core_a  <= 32'd0;
                        r_w_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Index saturates at 15 so a 17th word can never be taken.
                    if (w_accept) begin
                        if (r_idx == 4'd15) begin
                            r_state   <= S_WRITE;
                            r_w_ready <= 1'b0;
                            r_step    <= 6'd0;
                            r_core_a  <= 32'd0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // step[5:2] is the word number, step[1] selects address/data half.
                    r_step <= r_step + 6'd1;
                    case (r_step[1:0])
                        2'd1: r_core_d <= r_words[r_step[5:2]];
                        2'd3: begin
                            if (r_step[5:2] == 4'd15) begin
                                r_state  <= S_START;
                                r_core_a <= c_addr_start;
                            end else begin
                                r_core_a <= {28'd0, r_step[5:2] + 4'd1};
                            end
                        end
                        default: ;
                    endcase
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_step  <= 6'd0;
`ifdef SHA_LOADER_TIMEOUT_EN
                    r_tmo   <= 16'd0;
`endif
                end
                S_WAIT: begin
                    if (w_wait_exit) begin
                        r_state  <= S_READ;
                        r_step   <= 6'd0;
                        r_core_a <= c_addr_h0;
                    end
`ifdef SHA_LOADER_TIMEOUT_EN
                    else if (r_abort) begin
                        r_step <= r_step + 6'd1;
                        if (r_step[0]) begin
                            r_state   <= S_IDLE;
                            r_abort   <= 1'b0;
                            r_idx     <= 4'd0;
                            r_core_a  <= 32'd0;
                            r_core_d  <= 32'd0;
                            r_w_ready <= 1'b1;
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        r_err    <= 1'b1;
                        r_abort  <= 1'b1;
                        r_step   <= 6'd0;
                        r_core_a <= c_addr_init0;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
`endif
                end
                S_READ: begin
                    // The core's read data is valid on the second cycle of each address.
                    r_step <= r_step + 6'd1;
                    if (r_step[0]) begin
                        r_h[r_step[3:1]] <= core_dout;
                        if (r_step[3:1] == 3'd7) begin
                            r_state     <= S_OUT;
                            r_dig_valid <= 1'b1;
                            r_core_a    <= 32'd0;
                        end else begin
                            r_core_a <= c_addr_h0 + {29'd0, r_step[3:1] + 3'd1};
                        end
                    end
                end
                S_OUT: begin
                    if (dig_ready) begin
                        r_state     <= S_IDLE;
                        r_dig_valid <= 1'b0;
                        r_idx       <= 4'd0;
                        r_w_ready   <= 1'b1;
                        r_core_a    <= 32'd0;
                        r_core_d    <= 32'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ready   = r_w_ready;
    assign core_a    = r_core_a;
    assign core_d    = r_core_d;
    assign dig_valid = r_dig_valid;
    assign dig_data  = r_h;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_block_loader
// Brief    : Randomised bench for sha_block_loader with a behavioural SHA-256
//            core and a software digest model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_block_loader;
    localparam logic [255:0] c_iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [0:63][31:0] c_k = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [511:0] c_abc     = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] c_abc_dig = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic         clk_in    = 1'b0;
    logic         rst_in    = 1'b1;
    logic         first_in  = 1'b0;
    logic         w_valid   = 1'b0;
    logic [31:0]  w_data    = 32'd0;
    logic         w_ready;
    logic [31:0]  core_a;
    logic [31:0]  core_d;
    logic [31:0]  core_dout = 32'd0;
    logic [31:0]  core_status;
    logic         dig_valid;
    logic [255:0] dig_data;
    logic         dig_ready = 1'b0;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    sha_block_loader dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .first_in    (first_in),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .core_a      (core_a),
        .core_d      (core_d),
        .core_dout   (core_dout),
        .core_status (core_status),
        .dig_valid   (dig_valid),
        .dig_data    (dig_data),
        .dig_ready   (dig_ready),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + c_k[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Behavioural hash core: address-mapped message words, init, start, digest read.
    logic [511:0] cm_blk   = '0;
    logic [255:0] cm_h     = '0;
    logic [255:0] cm_pend  = '0;
    logic         cm_done  = 1'b0;
    logic         cm_stall = 1'b0;
    logic [31:0]  cm_prev_a = 32'd0;
    int           cm_cnt   = 0;

    assign core_status = {31'd0, cm_done};

    always @(posedge clk_in) begin
        cm_prev_a <= core_a;
        if (core_a >= 32'h10 && core_a < 32'h18)
            core_dout <= 32'(cm_h >> (32 * (7 - int'(core_a[2:0]))));
        else
            core_dout <= 32'd0;
        if (core_a == 32'h2000_0000 || core_a == 32'h4000_0000) cm_h <= c_iv;
        if (core_a < 32'd16) cm_blk[511 - 32*int'(core_a[3:0]) -: 32] <= core_d;
        if (rst_in) begin
            cm_cnt  <= 0;
            cm_done <= 1'b0;
        end else if (core_a == 32'h8000_0000 && cm_prev_a != 32'h8000_0000) begin
            cm_done <= 1'b0;
            cm_pend <= sha_compress(cm_h, cm_blk);
            cm_cnt  <= 3 + int'($urandom_range(0, 6));
        end else if (cm_cnt > 1) begin
            cm_cnt <= cm_cnt - 1;
        end else if (cm_cnt == 1 && !cm_stall) begin
            cm_cnt  <= 0;
            cm_done <= 1'b1;
            cm_h    <= cm_pend;
        end
    end

    int           mon_hs = 0, mon_i0 = 0, mon_i1 = 0, mon_dchg = 0;
    logic         mon_pv = 1'b0;
    logic [255:0] mon_pd = '0;
    always @(posedge clk_in) begin
        if (w_valid && w_ready) mon_hs <= mon_hs + 1;
        if (core_a == 32'h2000_0000) mon_i0 <= mon_i0 + 1;
        if (core_a == 32'h4000_0000) mon_i1 <= mon_i1 + 1;
        if (dig_valid && mon_pv && dig_data != mon_pd) mon_dchg <= mon_dchg + 1;
        mon_pv <= dig_valid;
        mon_pd <= dig_data;
    end

    logic [255:0] ref_h  = '0;
    bit           ref_ok = 1'b0;

    task automatic junk();
        w_valid = ($urandom_range(0, 3) == 0);
        w_data  = $urandom;
    endtask

    // mode 0: normal block, 1: reset during word 7 of WRITE, 2: core never finishes
    task automatic run_block(input logic [511:0] blk, input bit first, input int gap,
                             input int stall, input int mode, output logic [255:0] got);
        int hs0, i00, i10, bad, t;
        logic [255:0] exp;
        hs0 = mon_hs; i00 = mon_i0; i10 = mon_i1;
        got = '0;
        exp = sha_compress(first ? c_iv : ref_h, blk);
        for (int i = 0; i < 16; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                w_valid = 1'b0;
                repeat (gap == 1 ? 1 : int'($urandom_range(1, 3))) @(posedge clk_in);
                #1;
            end
            w_valid  = 1'b1;
            w_data   = blk[511 - 32*i -: 32];
            first_in = (i == 0) ? first : 1'($urandom);
            t = 0;
            while (!w_ready && t < 100) begin
                @(posedge clk_in); #1; t++;
            end
            if (t >= 100) begin
                chk("load_handshake_timeout", 0, 1);
                w_valid = 1'b0;
                return;
            end
            @(posedge clk_in); #1;
        end
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            if (mode == 1 && c == 29) begin
                w_valid = 1'b0;
                #2 rst_in = 1'b1;
                #1 chk("rst_midwrite_outputs", {w_ready, core_a, core_d, dig_valid, dig_data, busy, err}, '0);
                @(posedge clk_in); #1;
                rst_in = 1'b0;
                chk("rst_wready_still_low", w_ready, 0);
                @(posedge clk_in); #1;
                chk("rst_wready_rise", w_ready, 1);
                ref_ok = 1'b0;
                return;
            end
            if (core_a !== 32'(c / 4)) bad++;
            if (c % 4 >= 2 && core_d !== blk[511 - 32*(c/4) -: 32]) bad++;
            if (w_ready !== 1'b0 || busy !== 1'b1) bad++;
            junk();
            @(posedge clk_in); #1;
        end
        w_valid = 1'b0;
        chk("write_sequence", bad, 0);
        chk("start_addr", core_a, 32'h8000_0000);
`ifdef SHA_LOADER_TIMEOUT_EN
        if (mode == 2) begin
            bad = 0; t = 0;
            while (core_a !== 32'h2000_0000 && t < 5000) begin
                if (err !== 1'b0 || w_ready !== 1'b0) bad++;
                @(posedge clk_in); #1; t++;
            end
            chk("tmo_wait_cycles", t, 4097);
            chk("tmo_err_set", err, 1);
            chk("tmo_early_err", bad, 0);
            @(posedge clk_in); #1;
            chk("tmo_abort_hold", core_a, 32'h2000_0000);
            @(posedge clk_in); #1;
            chk("tmo_back_idle", {core_a, w_ready, busy, dig_valid}, {32'h0, 1'b1, 1'b0, 1'b0});
            repeat (5) @(posedge clk_in);
            #1 chk("tmo_err_sticky", err, 1);
            ref_ok = 1'b0;
            return;
        end
`endif
        bad = 0; t = 0;
        while (!dig_valid && t < 300) begin
            if (w_ready !== 1'b0) bad++;
            junk();
            @(posedge clk_in); #1; t++;
        end
        chk("wready_low_busy", bad, 0);
        if (!dig_valid) begin
            chk("digest_timeout", 0, 1);
            w_valid = 1'b0;
            return;
        end
        got = dig_data;
        chk("digest_model", dig_data, exp);
        bad = 0;
        repeat (stall) begin
            if (dig_valid !== 1'b1 || w_ready !== 1'b0 || dig_data !== got) bad++;
            junk();
            @(posedge clk_in); #1;
        end
        chk("out_hold", bad, 0);
        w_valid   = 1'b0;
        dig_ready = 1'b1;
        @(posedge clk_in); #1;
        dig_ready = 1'b0;
        chk("idle_after_out", {dig_valid, busy, w_ready}, 3'b001);
        chk("handshakes", mon_hs - hs0, 16);
        chk("init_a0_cycles", mon_i0 - i00, first ? 2 : 0);
        chk("init_a1_cycles", mon_i1 - i10, first ? 2 : 0);
        ref_h  = exp;
        ref_ok = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] got;
        logic [511:0] blk;
        bit           first;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 chk("reset_state", {w_ready, core_a, core_d, dig_valid, dig_data, busy, err}, '0);
        rst_in = 1'b0;
        chk("wready_before_edge", w_ready, 0);
        @(posedge clk_in); #1;
        chk("wready_after_reset", w_ready, 1);

        run_block(c_abc, 1'b1, 0, 2, 0, got);
        chk("abc_digest", got, c_abc_dig);
        run_block(c_abc, 1'b1, 1, 50, 0, got);
        chk("abc_digest_gapped", got, c_abc_dig);
        run_block(c_abc, 1'b1, 2, 0, 1, got);
        run_block(c_abc, 1'b1, 0, 1, 0, got);
        chk("abc_after_reset", got, c_abc_dig);
        for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
        run_block(blk, 1'b0, 2, 3, 0, got);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
            first = ref_ok ? 1'($urandom) : 1'b1;
            run_block(blk, first, int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), 0, got);
        end

`ifdef SHA_LOADER_TIMEOUT_EN
        cm_stall = 1'b1;
        run_block(c_abc, 1'b1, 0, 0, 2, got);
        cm_stall = 1'b0;
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        chk("tmo_err_cleared", err, 0);
        @(posedge clk_in); #1;
        run_block(c_abc, 1'b1, 0, 1, 0, got);
        chk("abc_after_timeout", got, c_abc_dig);
`else
        chk("err_tied_low", err, 0);
`endif
        chk("dig_data_stable", mon_dchg, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sha_block_loader.md
SHA_BLOCK_LOADER -- requirements
Module: sha_block_loader

Interface
REQ-001 The module SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  asynchronous active-high reset.
REQ-004 first_in  input  1  sampled with the first accepted word of a block; 1 = new message (re-init hash state), 0 = chain onto previous digest.
REQ-005 w_valid / w_data  input  1 / 32  message word stream, big-endian words in order 0..15 of a pre-padded 512-bit block.
REQ-006 w_ready  output  1  word accepted when w_valid and w_ready are both high on a rising edge.
REQ-007 core_a  output  32  address bus to the hash core's a_in.
REQ-008 core_d  output  32  write data to the hash core's d_in.
REQ-009 core_dout  input  32  read data from the hash core's d_out.
REQ-010 core_status  input  32  core status; bit 0 = digest done.
REQ-011 dig_valid / dig_data  output  1 / 256  digest, H0 in bits [255:224] through H7 in bits [31:0].
REQ-012 dig_ready  input  1  digest consumed when dig_valid and dig_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky timeout flag (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, INIT, LOAD, WRITE, START, WAIT, READ, OUT.
REQ-016 IDLE: w_ready=1; on accept, store word 0 and first_in, index=1; go to INIT if first_in=1, else to LOAD.
REQ-017 INIT: core_a=0x20000000 for 2 cycles, then 0x40000000 for 2 cycles, then LOAD; core_d=0.
REQ-018 LOAD: w_ready=1 until index=16; each accepted word is stored at index and index increments; at index=16 go to WRITE.
REQ-019 WRITE: for n=0..15, core_a=n held 2 cycles, then core_d=word[n] held 2 cycles with core_a unchanged (64 cycles total).
REQ-020 START: core_a=0x80000000 for 1 cycle, then WAIT.
REQ-021 WAIT: core_a holds 0x80000000; go to READ on the first cycle core_status[0]=1.
REQ-022 READ: for i=0..7, core_a=0x00000010+i for 2 cycles; core_dout is captured into H[i] on the second cycle.
REQ-023 OUT: dig_valid=1 with dig_data stable until handshake, then IDLE.
REQ-024 dig_data SHALL NOT change while dig_valid=1.
REQ-025 w_ready SHALL be 0 in INIT, WRITE, START, WAIT, READ and OUT; words offered there SHALL NOT be consumed.
REQ-026 The 4-bit word index SHALL wrap to 0 only on entry to IDLE; no 17th word is accepted per block.
REQ-027 w_valid gaps in LOAD SHALL stall the FSM without a timeout.
REQ-028 core_a and core_d SHALL be registered outputs; in IDLE core_a=0x00000000 and core_d=0x00000000.

Reset
REQ-029 Assertion of rst_in in any state SHALL immediately force IDLE, index=0, w_ready=0 while asserted, dig_valid=0, dig_data=0, core_a=0, core_d=0, busy=0, err=0.
REQ-030 A partially loaded or in-flight block SHALL be discarded on reset; the next block SHALL require first_in=1 to be meaningful.
REQ-031 w_ready SHALL rise on the first rising edge after rst_in deasserts.

Configuration
REQ-032 Macro SHA_LOADER_TIMEOUT_EN defined: a 16-bit counter runs in WAIT; at 4096 cycles without done, set err=1, drive core_a=0x20000000 for 2 cycles, and return to IDLE with no digest; err clears only on reset.
REQ-033 Macro SHA_LOADER_TIMEOUT_EN undefined: WAIT has no limit, the counter is absent, and err is tied to 0.

Verification
REQ-034 Reset, then "abc" block (0x61626380, 14x0, 0x00000018), first_in=1 -> dig_data=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-035 Same block with w_valid toggled every other cycle -> identical digest, exactly 16 handshakes, core_a write sequence 0..F unchanged.
REQ-036 Hold dig_ready=0 for 50 cycles in OUT -> dig_valid held, dig_data stable, w_ready=0 throughout.
REQ-037 Assert rst_in mid-WRITE (at n=7) -> all outputs 0 same cycle; a new "abc" block afterwards gives the correct digest.
REQ-038 With SHA_LOADER_TIMEOUT_EN, core_status[0] tied 0 -> err=1 after 4096 WAIT cycles, core_a=0x20000000 for 2 cycles, then IDLE with w_ready=1.
REQ-039 Two-block message ("abc" block with first_in=1, then second block with first_in=0) -> no INIT writes for block 2; second digest matches the software model.
